// File: rtl/sel_input_scan_seq.sv
// sel_input_scan_seq: autonomous scan initiator for the input selector.
// Walks the mux through [first_ch..last_ch] (wrapping at NUM_CH-1). For each
// channel it enables the mux, waits for sel_active, waits the settle interval,
// requests one sample and waits for the acknowledge. After the last channel,
// an abort or a timeout, it disables the mux and waits for the pause to end.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, abort          one-cycle control pulses
//   first_ch, last_ch     channel range, captured on an accepted start
//   settle                settle cycles after sel_active, captured on start
//   sel_wr, sel_data      select-write strobe and word {.., en, channel}
//   sel_active            selector active / pause-pending flag
//   smp_req, smp_ch       sample request (level) and its channel
//   smp_ack               one-cycle sample acknowledge
//   busy, done, err       status: scan running, end pulse, sticky error
//   cur_ch                channel currently being handled
module sel_input_scan_seq #(
  parameter int unsigned CH_W     = 8,
  parameter int unsigned NUM_CH   = 157,
  parameter int unsigned SETTLE_W = 16,
  parameter int unsigned TMO      = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CH_W-1:0]     first_ch,
  input  logic [CH_W-1:0]     last_ch,
  input  logic [SETTLE_W-1:0] settle,
  output logic                sel_wr,
  output logic [31:0]         sel_data,
  input  logic                sel_active,
  output logic                smp_req,
  output logic [CH_W-1:0]     smp_ch,
  input  logic                smp_ack,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CH_W-1:0]     cur_ch
);

  localparam int unsigned TMO_W = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT_ON,
    S_SETTLE,
    S_SAMPLE,
    S_NEXT,
    S_DISABLE,
    S_WAIT_OFF,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]     last_q, last_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] scnt_q, scnt_d;
  logic [TMO_W-1:0]    tmr_q, tmr_d;
  logic                abort_q, abort_d;

  logic                sel_wr_d;
  logic [31:0]         sel_data_d;
  logic                smp_req_d;
  logic [CH_W-1:0]     smp_ch_d;
  logic                busy_d;
  logic                done_d;
  logic                err_d;
  logic [CH_W-1:0]     cur_ch_d;

  logic range_bad;
  logic tmo_hit;
  logic abort_any;

  assign range_bad = (first_ch > LAST_CH) || (last_ch > LAST_CH);
  assign tmo_hit   = (tmr_q == TMO_LAST);
  // An abort seen during SELECT is held so WAIT_ON can leave on the next
  // transition without putting two sel_wr strobes back to back.
  assign abort_any = abort || abort_q;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= '0;
      settle_q <= '0;
      scnt_q   <= '0;
      tmr_q    <= '0;
      abort_q  <= 1'b0;
      sel_wr   <= 1'b0;
      sel_data <= '0;
      smp_req  <= 1'b0;
      smp_ch   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cur_ch   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      settle_q <= settle_d;
      scnt_q   <= scnt_d;
      tmr_q    <= tmr_d;
      abort_q  <= abort_d;
      sel_wr   <= sel_wr_d;
      sel_data <= sel_data_d;
      smp_req  <= smp_req_d;
      smp_ch   <= smp_ch_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      cur_ch   <= cur_ch_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = range_bad ? S_DONE : S_SELECT;
      S_SELECT:   state_d = S_WAIT_ON;
      S_WAIT_ON: begin
        if (abort_any)       state_d = S_DISABLE;
        else if (sel_active) state_d = S_SETTLE;
        else if (tmo_hit)    state_d = S_DISABLE;
      end
      S_SETTLE: begin
        if (abort)              state_d = S_DISABLE;
        else if (scnt_q == '0)  state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)        state_d = S_DISABLE;
        else if (smp_ack) state_d = S_NEXT;
      end
      S_NEXT:     state_d = (abort || (cur_ch == last_q)) ? S_DISABLE : S_SELECT;
      S_DISABLE:  state_d = S_WAIT_OFF;
      S_WAIT_OFF: if (!sel_active || tmo_hit) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath updates and next values of the registered outputs
  always_comb begin
    last_d     = last_q;
    settle_d   = settle_q;
    scnt_d     = scnt_q;
    tmr_d      = tmr_q;
    abort_d    = abort_q;
    err_d      = err;
    cur_ch_d   = cur_ch;
    sel_data_d = sel_data;
    smp_ch_d   = smp_ch;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          last_d   = last_ch;
          settle_d = settle;
          err_d    = range_bad;
          abort_d  = 1'b0;
          if (!range_bad) cur_ch_d = first_ch;
        end
      end
      S_SELECT: begin
        tmr_d = '0;
        if (abort) abort_d = 1'b1;
      end
      S_WAIT_ON: begin
        tmr_d  = tmr_q + TMO_W'(1);
        scnt_d = settle_q;
        if (!abort_any && !sel_active && tmo_hit) err_d = 1'b1;
      end
      S_SETTLE: begin
        if (scnt_q != '0) scnt_d = scnt_q - SETTLE_W'(1);
      end
      S_NEXT: begin
        if (state_d == S_SELECT)
          cur_ch_d = (cur_ch == LAST_CH) ? '0 : cur_ch + CH_W'(1);
      end
      S_DISABLE: begin
        tmr_d   = '0;
        abort_d = 1'b0;
      end
      S_WAIT_OFF: begin
        tmr_d = tmr_q + TMO_W'(1);
        if (sel_active && tmo_hit) err_d = 1'b1;
      end
      default: ;
    endcase

    sel_wr_d  = (state_d == S_SELECT) || (state_d == S_DISABLE);
    smp_req_d = (state_d == S_SAMPLE);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);

    // The select word is held between strobes.
    if (state_d == S_SELECT)
      sel_data_d = 32'({1'b1, cur_ch_d});
    else if (state_d == S_DISABLE)
      sel_data_d = 32'({1'b0, cur_ch_d});

    if (state_d == S_SAMPLE) smp_ch_d = cur_ch_d;
  end

endmodule

// File: tb/tb_sel_input_scan_seq.sv
// Directed bench for sel_input_scan_seq with a small input-selector model
// that answers select words and sample requests.
module tb_sel_input_scan_seq;

  localparam int unsigned CH_W     = 8;
  localparam int unsigned NUM_CH   = 157;
  localparam int unsigned SETTLE_W = 16;
  localparam int unsigned TMO      = 4096;
  localparam int ON_DLY  = 3;
  localparam int OFF_DLY = 2;
  localparam int ACK_DLY = 4;

  logic                clk;
  logic                rst;
  logic                start;
  logic                abort;
  logic [CH_W-1:0]     first_ch;
  logic [CH_W-1:0]     last_ch;
  logic [SETTLE_W-1:0] settle;
  logic                sel_wr;
  logic [31:0]         sel_data;
  logic                sel_active;
  logic                smp_req;
  logic [CH_W-1:0]     smp_ch;
  logic                smp_ack;
  logic                busy;
  logic                done;
  logic                err;
  logic [CH_W-1:0]     cur_ch;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_done = 0;
  int done_cyc = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  bit resp_en = 1'b1;

  logic [31:0] wq[$];
  logic [31:0] sq[$];
  logic [31:0] lq[$];
  int          wcyc[$];
  logic [31:0] e[$];

  sel_input_scan_seq #(
    .CH_W(CH_W), .NUM_CH(NUM_CH), .SETTLE_W(SETTLE_W), .TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_ch(first_ch), .last_ch(last_ch), .settle(settle),
    .sel_wr(sel_wr), .sel_data(sel_data), .sel_active(sel_active),
    .smp_req(smp_req), .smp_ch(smp_ch), .smp_ack(smp_ack),
    .busy(busy), .done(done), .err(err), .cur_ch(cur_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$]);
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : 32'hDEAD_BEEF, exp[i]);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sel_wr"},   32'(sel_wr),  32'd0);
    check({tag, "_sel_data"}, sel_data,     32'd0);
    check({tag, "_smp_req"},  32'(smp_req), 32'd0);
    check({tag, "_smp_ch"},   32'(smp_ch),  32'd0);
    check({tag, "_busy"},     32'(busy),    32'd0);
    check({tag, "_done"},     32'(done),    32'd0);
    check({tag, "_err"},      32'(err),     32'd0);
    check({tag, "_cur_ch"},   32'(cur_ch),  32'd0);
  endtask

  task automatic clear_log();
    wq.delete();
    sq.delete();
    lq.delete();
    wcyc.delete();
    n_done = 0;
  endtask

  // Called at a negedge; start is sampled by the next posedge.
  task automatic do_start(input logic [CH_W-1:0] f, input logic [CH_W-1:0] l,
                          input logic [SETTLE_W-1:0] s);
    first_ch  = f;
    last_ch   = l;
    settle    = s;
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  // Input-selector model: drops sel_active on a new enable word and raises it
  // ON_DLY cycles later; drops it OFF_DLY cycles after a disable word; acks
  // each sample request ACK_DLY cycles after it appears.
  initial begin : selector_model
    int on_cnt;
    int off_cnt;
    int ack_cnt;
    bit ack_armed;
    sel_active = 1'b0;
    smp_ack    = 1'b0;
    on_cnt = 0; off_cnt = 0; ack_cnt = 0; ack_armed = 1'b0;
    forever begin
      @(negedge clk);
      smp_ack = 1'b0;
      if (rst) begin
        sel_active = 1'b0;
        on_cnt = 0; off_cnt = 0; ack_cnt = 0; ack_armed = 1'b0;
      end else begin
        if (on_cnt > 0) begin
          on_cnt--;
          if (on_cnt == 0) begin
            sel_active = 1'b1;
            rise_cyc   = cyc + 1;
          end
        end
        if (off_cnt > 0) begin
          off_cnt--;
          if (off_cnt == 0) sel_active = 1'b0;
        end
        if (sel_wr) begin
          if (sel_data[CH_W]) begin
            sel_active = 1'b0;
            if (resp_en) on_cnt = ON_DLY;
          end else begin
            on_cnt  = 0;
            off_cnt = OFF_DLY;
          end
        end
        if (!smp_req) begin
          ack_armed = 1'b0;
          ack_cnt   = 0;
        end else if (!ack_armed) begin
          ack_armed = 1'b1;
          ack_cnt   = ACK_DLY;
        end else if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) smp_ack = 1'b1;
        end
      end
    end
  end

  // Log of select words, sample channels, settle latency and done pulses.
  initial begin : monitor
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (sel_wr) begin
        wq.push_back(sel_data);
        wcyc.push_back(cyc);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (smp_req && !req_prev) begin
        sq.push_back(32'(smp_ch));
        lq.push_back(32'(cyc - rise_cyc));
      end
      req_prev = smp_req;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit found;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    first_ch = '0; last_ch = '0; settle = '0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    // Plain range 5..7, settle 10; a second start mid-scan must be ignored.
    clear_log();
    do_start(8'd5, 8'd7, 16'd10);
    check("t1_busy", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
    do_start(8'd30, 8'd30, 16'd0);
    wait_done(600, "t1");
    repeat (5) @(negedge clk);
    e = '{32'h105, 32'h106, 32'h107, 32'h007};
    check_q("t1_sel", wq, e);
    e = '{32'd5, 32'd6, 32'd7};
    check_q("t1_smp_ch", sq, e);
    e = '{32'd11, 32'd11, 32'd11};
    check_q("t1_settle_lat", lq, e);
    check("t1_done_cnt", 32'(n_done), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Wrapping range 155..1.
    clear_log();
    do_start(8'd155, 8'd1, 16'd0);
    wait_done(600, "t2");
    repeat (5) @(negedge clk);
    e = '{32'h19B, 32'h19C, 32'h100, 32'h101, 32'h001};
    check_q("t2_sel", wq, e);
    e = '{32'd155, 32'd156, 32'd0, 32'd1};
    check_q("t2_smp_ch", sq, e);
    check("t2_err", 32'(err), 32'd0);

    // Selector never becomes active: timeout in WAIT_ON.
    clear_log();
    resp_en = 1'b0;
    do_start(8'd3, 8'd4, 16'd2);
    wait_done(5000, "t3");
    repeat (5) @(negedge clk);
    resp_en = 1'b1;
    e = '{32'h103, 32'h003};
    check_q("t3_sel", wq, e);
    check("t3_tmo_cycles", (wcyc.size() == 2) ? 32'(wcyc[1] - wcyc[0]) : 32'hFFFF_FFFF, 32'd4097);
    check("t3_err", 32'(err), 32'd1);
    check("t3_done_cnt", 32'(n_done), 32'd1);

    // Abort while the second channel's sample is requested.
    clear_log();
    do_start(8'd4, 8'd9, 16'd1);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk);
      #2;
      if (smp_req && smp_ch == 8'd5) found = 1'b1;
    end
    check("t4_reach_ch5", 32'(found), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    check("t4_smp_req_drop", 32'(smp_req), 32'd0);
    wait_done(100, "t4");
    repeat (10) @(negedge clk);
    e = '{32'h104, 32'h105, 32'h005};
    check_q("t4_sel", wq, e);
    check("t4_err", 32'(err), 32'd0);
    check("t4_smp_cnt", 32'(sq.size()), 32'd2);

    // Out-of-range channels: immediate error, no select words.
    clear_log();
    do_start(8'd200, 8'd3, 16'd0);
    wait_done(4, "t5a");
    check("t5a_fast", 32'((done_cyc - start_cyc) <= 2), 32'd1);
    check("t5a_err", 32'(err), 32'd1);
    do_start(8'd0, 8'd157, 16'd0);
    wait_done(4, "t5b");
    check("t5b_err", 32'(err), 32'd1);
    repeat (5) @(negedge clk);
    check("t5_no_sel", 32'(wq.size()), 32'd0);

    // Reset during SETTLE, then a normal scan.
    clear_log();
    do_start(8'd10, 8'd11, 16'd200);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (sel_active) found = 1'b1;
    end
    check("t6_active", 32'(found), 32'd1);
    repeat (5) @(negedge clk);
    check("t6_busy_mid", 32'(busy), 32'd1);
    check("t6_sel_mid", sel_data, 32'h10A);
    rst = 1'b1;
    @(negedge clk);
    check_reset("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
    do_start(8'd20, 8'd21, 16'd0);
    wait_done(300, "t6");
    repeat (5) @(negedge clk);
    e = '{32'h114, 32'h115, 32'h015};
    check_q("t6_sel", wq, e);
    check("t6_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
